locked_register_bank: RTL and testbench

Bank of NUM_REGS lockable configuration registers, DATA_W bits each, replacing the single locked register in the security-configuration path. Each register carries its own sticky lock bit, set by software and cleared only by reset. A trusted debug agent can write locked registers only after a timed unlock sequence. Rejected writes are flagged and counted for the security monitor.

---
 rtl/locked_reg_pkg.sv | 25 ++
 rtl/debug_unlock_fsm.sv | 70 +++++++
 rtl/locked_register_bank.sv | 112 +++++++++++
 tb/tb_locked_register_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/locked_reg_pkg.sv
// Shared types and defaults for the lockable register bank.
// Holds the debug-unlock state enum and the saturating counter helper.
package locked_reg_pkg;

  localparam int DEF_DATA_W        = 16;
  localparam int DEF_NUM_REGS      = 4;
  localparam int DEF_UNLOCK_CYCLES = 8;
  localparam int DEF_CNT_W         = 8;
  localparam int HOLD_CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    OPEN   = 2'd2
  } unlock_state_e;

  // Increment v, sticking at max once it is reached.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/debug_unlock_fsm.sv
// Timed unlock for the trusted debug agent: debug_mode & trusted must be
// held for UNLOCK_CYCLES edges before debug writes are let through.
module debug_unlock_fsm
  import locked_reg_pkg::*;
#(
  parameter int UNLOCK_CYCLES = DEF_UNLOCK_CYCLES
) (
  input  logic Clk,
  input  logic reset,
  input  logic debug_mode,
  input  logic trusted,
  output logic debug_open
);

  unlock_state_e           state_q, state_d;
  logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    go;
  logic [HOLD_CNT_W-1:0]   cnt_inc;

  assign go      = debug_mode & trusted;
  assign cnt_inc = cnt_q + HOLD_CNT_W'(1);

  // State and hold counter registers
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: arm on request, open once the hold reaches the target
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          cnt_d   = HOLD_CNT_W'(1);
          state_d = (UNLOCK_CYCLES == 1) ? OPEN : ARMING;
        end
      end
      ARMING: begin
        if (!go) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == HOLD_CNT_W'(UNLOCK_CYCLES))
            state_d = OPEN;
        end
      end
      OPEN: begin
        if (!go) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign debug_open = (state_q == OPEN);

endmodule

// File: rtl/locked_register_bank.sv
// Bank of sticky-lockable config registers with debug override.
// Optional violation counter: define LOCKED_REG_VIOLATION_CNT_EN.
module locked_register_bank
  import locked_reg_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int ADDR_W        = $clog2(NUM_REGS),
  parameter int UNLOCK_CYCLES = DEF_UNLOCK_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [DATA_W-1:0]   Data_in,
  input  logic                write,
  input  logic                Lock,
  input  logic                Lock_all,
  input  logic                trusted,
  input  logic                debug_mode,
  input  logic [ADDR_W-1:0]   Rd_addr,
  output logic [DATA_W-1:0]   Data_out,
  output logic [NUM_REGS-1:0] lock_status,
  output logic                debug_open,
  output logic                violation,
  output logic [CNT_W-1:0]    violation_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] lock_q, lock_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                viol_q, viol_d;
  logic                accept;
  logic                reject;

  debug_unlock_fsm #(
    .UNLOCK_CYCLES(UNLOCK_CYCLES)
  ) u_fsm (
    .Clk       (Clk),
    .reset     (reset),
    .debug_mode(debug_mode),
    .trusted   (trusted),
    .debug_open(debug_open)
  );

  // Pre-edge lock bit decides; a same-cycle Lock only bites next cycle
  always_comb begin
    accept = write & (~lock_q[Addr] | debug_open);
    reject = write & ~accept;
  end

  // Register array, lock vector, read data and violation next values
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      regs_d[i] = regs_q[i];
    if (accept)
      regs_d[Addr] = Data_in;
    lock_d = lock_q;
    if (Lock)
      lock_d = lock_d | (NUM_REGS'(1) << Addr);
    if (Lock_all)
      lock_d = '1;
    rdata_d = regs_q[Rd_addr];
    viol_d  = reject;
  end

  // Bank state registers
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      lock_q  <= '0;
      rdata_q <= '0;
      viol_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= regs_d[i];
      lock_q  <= lock_d;
      rdata_q <= rdata_d;
      viol_q  <= viol_d;
    end
  end

`ifdef LOCKED_REG_VIOLATION_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating rejected-write count
  always_comb begin
    cnt_d = cnt_q;
    if (reject)
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'({CNT_W{1'b1}})));
  end

  // Counter register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign violation_cnt = cnt_q;
`else
  assign violation_cnt = '0;
`endif

  assign Data_out    = rdata_q;
  assign lock_status = lock_q;
  assign violation   = viol_q;

endmodule

// File: tb/tb_locked_register_bank.sv
// Directed bench for locked_register_bank (CNT_W = 2 instance).
// Expected counter values follow LOCKED_REG_VIOLATION_CNT_EN.
module tb_locked_register_bank;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic [15:0] din;
  logic        wr;
  logic        lock;
  logic        lock_all;
  logic        trusted;
  logic        dbg;
  logic [1:0]  rd_addr;
  logic [15:0] dout;
  logic [3:0]  lock_st;
  logic        dbg_open;
  logic        viol;
  logic [1:0]  viol_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int rejects    = 0;

  locked_register_bank #(
    .DATA_W       (16),
    .NUM_REGS     (4),
    .UNLOCK_CYCLES(8),
    .CNT_W        (2)
  ) dut (
    .Clk          (clk),
    .reset        (rst),
    .Addr         (addr),
    .Data_in      (din),
    .write        (wr),
    .Lock         (lock),
    .Lock_all     (lock_all),
    .trusted      (trusted),
    .debug_mode   (dbg),
    .Rd_addr      (rd_addr),
    .Data_out     (dout),
    .lock_status  (lock_st),
    .debug_open   (dbg_open),
    .violation    (viol),
    .violation_cnt(viol_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_cnt();
`ifdef LOCKED_REG_VIOLATION_CNT_EN
    return (rejects > 3) ? 2'd3 : 2'(rejects);
`else
    return 2'd0;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; addr = '0; din = '0; wr = 1'b0; lock = 1'b0;
    lock_all = 1'b0; trusted = 1'b0; dbg = 1'b0; rd_addr = '0;
    #12;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_lock", 32'(lock_st), 32'h0);
    chk("rst_open", 32'(dbg_open), 32'h0);
    chk("rst_viol", 32'(viol), 32'h0);
    chk("rst_cnt", 32'(viol_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // plain write then read
    addr = 2'd2; din = 16'hA5A5; wr = 1'b1; rd_addr = 2'd2;
    tick();
    wr = 1'b0;
    tick();
    chk("raw_r2", 32'(dout), 32'hA5A5);
    chk("raw_lock", 32'(lock_st), 32'h0);

    // lock reg 1, rejected write
    addr = 2'd1; lock = 1'b1;
    tick();
    lock = 1'b0;
    chk("lock1", 32'(lock_st), 32'h2);
    din = 16'h1234; wr = 1'b1; rd_addr = 2'd1;
    tick();
    wr = 1'b0; rejects++;
    chk("rej1_viol", 32'(viol), 32'h1);
    chk("rej1_cnt", 32'(viol_cnt), 32'(exp_cnt()));
    chk("rej1_r1", 32'(dout), 32'h0);
    tick();
    chk("rej1_pulse", 32'(viol), 32'h0);
    chk("rej1_keep", 32'(dout), 32'h0);
    addr = 2'd0; din = 16'h0077; wr = 1'b1; rd_addr = 2'd0;
    tick();
    wr = 1'b0;
    chk("wr0_viol", 32'(viol), 32'h0);
    tick();
    chk("wr0_r0", 32'(dout), 32'h0077);

    // write + lock same cycle
    addr = 2'd3; din = 16'hBEEF; wr = 1'b1; lock = 1'b1;
    tick();
    lock = 1'b0;
    chk("wl_lock", 32'(lock_st), 32'hA);
    chk("wl_viol", 32'(viol), 32'h0);
    din = 16'h0000; rd_addr = 2'd3;
    tick();
    wr = 1'b0; rejects++;
    chk("wl_rej", 32'(viol), 32'h1);
    chk("wl_cnt", 32'(viol_cnt), 32'(exp_cnt()));
    tick();
    chk("wl_r3", 32'(dout), 32'hBEEF);

    // lock all, timed unlock
    lock_all = 1'b1;
    tick();
    lock_all = 1'b0;
    chk("lockall", 32'(lock_st), 32'hF);
    dbg = 1'b1; trusted = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("arm7_closed", 32'(dbg_open), 32'h0);
    tick();
    chk("arm8_open", 32'(dbg_open), 32'h1);
    addr = 2'd0; din = 16'h5555; wr = 1'b1; rd_addr = 2'd0;
    tick();
    wr = 1'b0;
    chk("open_wr", 32'(viol), 32'h0);
    tick();
    chk("open_r0", 32'(dout), 32'h5555);

    // dropping debug_mode: same-cycle write still lands
    dbg = 1'b0; addr = 2'd1; din = 16'h0F0F; wr = 1'b1; rd_addr = 2'd1;
    tick();
    wr = 1'b0;
    chk("drop_open", 32'(dbg_open), 32'h0);
    chk("drop_viol", 32'(viol), 32'h0);
    tick();
    chk("drop_r1", 32'(dout), 32'h0F0F);

    // retry, trusted drops at cycle 5
    dbg = 1'b1; trusted = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    trusted = 1'b0;
    tick();
    chk("retry_idle", 32'(dbg_open), 32'h0);
    dbg = 1'b0;
    addr = 2'd2; din = 16'h1111; wr = 1'b1; rd_addr = 2'd2;
    tick();
    wr = 1'b0; rejects++;
    chk("retry_rej", 32'(viol), 32'h1);
    chk("retry_cnt", 32'(viol_cnt), 32'(exp_cnt()));
    tick();
    chk("retry_r2", 32'(dout), 32'hA5A5);

    // debug_mode without trusted never opens
    dbg = 1'b1; trusted = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("untrusted", 32'(dbg_open), 32'h0);
    dbg = 1'b0;

    // back-to-back rejections, counter saturates
    addr = 2'd0; din = 16'hFFFF; wr = 1'b1;
    tick();
    rejects++;
    chk("b2b_v1", 32'(viol), 32'h1);
    chk("b2b_c1", 32'(viol_cnt), 32'(exp_cnt()));
    tick();
    wr = 1'b0; rejects++;
    chk("b2b_v2", 32'(viol), 32'h1);
    chk("b2b_sat", 32'(viol_cnt), 32'(exp_cnt()));
    tick();
    chk("b2b_end", 32'(viol), 32'h0);
    chk("b2b_hold", 32'(viol_cnt), 32'(exp_cnt()));

    // reset mid-ARMING
    dbg = 1'b1; trusted = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    rejects = 0;
    chk("mid_dout", 32'(dout), 32'h0);
    chk("mid_lock", 32'(lock_st), 32'h0);
    chk("mid_open", 32'(dbg_open), 32'h0);
    chk("mid_cnt", 32'(viol_cnt), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("rearm7", 32'(dbg_open), 32'h0);
    tick();
    chk("rearm8", 32'(dbg_open), 32'h1);
    dbg = 1'b0; trusted = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
